// File: rtl/toast_regfile_pkg.sv
// -----------------------------------------------------------------------------
// toast_regfile_pkg
// Shared definitions for the multi-port integer register file:
//   - default width / depth / port-count constants
//   - clear-engine state encoding (CLEAR = 1'b0, RUN = 1'b1)
//   - lane_lsb(): bit offset of lane k inside a packed per-lane bus
// -----------------------------------------------------------------------------
package toast_regfile_pkg;

  localparam int DATA_WIDTH_DEF   = 32;
  localparam int ADDR_WIDTH_DEF   = 5;
  localparam int DEPTH_DEF        = 32;
  localparam int NUM_RD_PORTS_DEF = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // Lane k of a packed bus whose lanes are 'width' bits wide starts here.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/toast_regfile_rdport.sv
// -----------------------------------------------------------------------------
// toast_regfile_rdport
// One combinational read lane of the register file with write-through bypass.
//
// Ports:
//   busy      in   clear engine active; lane forced to zero
//   rs_addr   in   read address of this lane
//   wr0_*     in   write port 0 (older instruction) enable/address/data
//   wr1_*     in   write port 1 (younger instruction) enable/address/data
//   arr_data  in   array entry selected by rs_addr
//   rs_data   out  read result
//   byp_hit   out  result came from a same-cycle write (entry is being written)
//
// Port 1 bypass is checked before port 0 so the value read in the write cycle
// is the same one the array holds afterwards (port 1 wins on a same-address
// double write).
// -----------------------------------------------------------------------------
module toast_regfile_rdport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  busy,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic                  wr0_en,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  input  logic                  wr1_en,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  input  logic [DATA_WIDTH-1:0] arr_data,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic                  byp_hit
);

  always_comb begin
    rs_data = arr_data;
    byp_hit = 1'b0;
    if (busy || (rs_addr == '0)) begin
      // x0 is hardwired; during clear the array is not yet trustworthy
      rs_data = '0;
    end else if (wr1_en && (wr1_addr == rs_addr)) begin
      rs_data = wr1_data;
      byp_hit = 1'b1;
    end else if (wr0_en && (wr0_addr == rs_addr)) begin
      rs_data = wr0_data;
      byp_hit = 1'b1;
    end
  end

endmodule

// File: rtl/toast_regfile_mp.sv
// -----------------------------------------------------------------------------
// toast_regfile_mp
// Integer register file: NUM_RD_PORTS combinational read lanes, two write
// ports (wr0 = older, wr1 = younger instruction), same-cycle write-through
// bypass, x0 hardwired to zero. The array has no per-entry reset; after reset
// a sequential clear engine zeroes entries 1..DEPTH-1, one per cycle, while
// busy_o stalls the pipeline.
//
// Ports:
//   clk_i        in   clock, rising edge
//   reset_i      in   synchronous reset, active-high
//   rs_addr_i    in   packed read addresses, lane k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rs_data_o    out  packed read data,      lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wr0_en_i / wr0_addr_i / wr0_data_i   in   write port 0
//   wr1_en_i / wr1_addr_i / wr1_data_i   in   write port 1 (wins on same address)
//   busy_o       out  clear engine active
//   wr_drop_o    out  one-cycle pulse after an enabled write was discarded
//
// Optional feature, macro TOAST_REGFILE_SCOREBOARD_EN: DEPTH-bit pending
// scoreboard with extra ports
//   rsv_en_i / rsv_addr_i   in   reserve (set pending) a nonzero entry
//   rs_pend_o               out  per-lane pending flag
// -----------------------------------------------------------------------------
module toast_regfile_mp
  import toast_regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int NUM_RD_PORTS = NUM_RD_PORTS_DEF
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rs_addr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rs_data_o,
  input  logic                               wr0_en_i,
  input  logic [ADDR_WIDTH-1:0]              wr0_addr_i,
  input  logic [DATA_WIDTH-1:0]              wr0_data_i,
  input  logic                               wr1_en_i,
  input  logic [ADDR_WIDTH-1:0]              wr1_addr_i,
  input  logic [DATA_WIDTH-1:0]              wr1_data_i,
  output logic                               busy_o,
  output logic                               wr_drop_o
`ifdef TOAST_REGFILE_SCOREBOARD_EN
  ,
  input  logic                               rsv_en_i,
  input  logic [ADDR_WIDTH-1:0]              rsv_addr_i,
  output logic [NUM_RD_PORTS-1:0]            rs_pend_o
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

  rf_state_e             state_reg;
  logic [ADDR_WIDTH-1:0] clr_idx_reg;
  logic                  wr_drop_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                    busy;
  logic                    wr0_go;
  logic                    wr1_go;
  logic [NUM_RD_PORTS-1:0] byp_hit;

  assign busy      = (state_reg == CLEAR);
  assign busy_o    = busy;
  assign wr_drop_o = wr_drop_reg;

  // A port write lands only in RUN, outside reset, to a nonzero entry.
  assign wr0_go = ~reset_i & ~busy & wr0_en_i & (wr0_addr_i != '0);
  assign wr1_go = ~reset_i & ~busy & wr1_en_i & (wr1_addr_i != '0);

  // ---------------------------------------------------------------------------
  // Clear engine. clr_idx saturates at the last entry; the edge that clears
  // that entry is also the one that enters RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg   <= CLEAR;
      clr_idx_reg <= FIRST_IDX;
      wr_drop_reg <= 1'b0;
    end else begin
      wr_drop_reg <= busy & (wr0_en_i | wr1_en_i);
      if (busy) begin
        if (clr_idx_reg == LAST_IDX) begin
          state_reg <= RUN;
        end else begin
          clr_idx_reg <= clr_idx_reg + FIRST_IDX;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array (no reset). Port 1 is written last so it wins on a
  // same-address double write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (busy) begin
      mem[clr_idx_reg] <= '0;
    end else begin
      if (wr0_go) mem[wr0_addr_i] <= wr0_data_i;
      if (wr1_go) mem[wr1_addr_i] <= wr1_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Read lanes
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
    localparam int ALSB = lane_lsb(gi, ADDR_WIDTH);
    localparam int DLSB = lane_lsb(gi, DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] lane_addr;
    assign lane_addr = rs_addr_i[ALSB +: ADDR_WIDTH];

    toast_regfile_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rdport (
      .busy     (busy),
      .rs_addr  (lane_addr),
      .wr0_en   (wr0_en_i),
      .wr0_addr (wr0_addr_i),
      .wr0_data (wr0_data_i),
      .wr1_en   (wr1_en_i),
      .wr1_addr (wr1_addr_i),
      .wr1_data (wr1_data_i),
      .arr_data (mem[lane_addr]),
      .rs_data  (rs_data_o[DLSB +: DATA_WIDTH]),
      .byp_hit  (byp_hit[gi])
    );
  end

`ifdef TOAST_REGFILE_SCOREBOARD_EN
  // ---------------------------------------------------------------------------
  // Pending scoreboard: writes clear, reserve sets; reserve is applied last so
  // a same-cycle reserve+write to one entry leaves it pending.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] pend_reg;
  logic [DEPTH-1:0] pend_next;

  always_comb begin
    pend_next = pend_reg;
    if (wr0_go) pend_next[wr0_addr_i] = 1'b0;
    if (wr1_go) pend_next[wr1_addr_i] = 1'b0;
    if (~busy & rsv_en_i & (rsv_addr_i != '0)) pend_next[rsv_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || busy) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  // A same-cycle write means the value is arriving via bypass, so the lane
  // is no longer waiting on it.
  for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_pend
    assign rs_pend_o[gi] = pend_reg[g_rd[gi].lane_addr] & ~byp_hit[gi] &
                           (g_rd[gi].lane_addr != '0);
  end
`else
  logic unused_byp_hit;
  assign unused_byp_hit = ^byp_hit;
`endif

endmodule

// File: tb/tb_toast_regfile_mp.sv
module tb_toast_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NP    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NP*AW-1:0] rs_addr;
  logic [NP*DW-1:0] rs_data;
  logic             wr0_en, wr1_en;
  logic [AW-1:0]    wr0_addr, wr1_addr;
  logic [DW-1:0]    wr0_data, wr1_data;
  logic             busy, wr_drop;
`ifdef TOAST_REGFILE_SCOREBOARD_EN
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic [NP-1:0]    rs_pend;
`endif

  toast_regfile_mp #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .NUM_RD_PORTS (NP)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .rs_addr_i  (rs_addr),
    .rs_data_o  (rs_data),
    .wr0_en_i   (wr0_en),
    .wr0_addr_i (wr0_addr),
    .wr0_data_i (wr0_data),
    .wr1_en_i   (wr1_en),
    .wr1_addr_i (wr1_addr),
    .wr1_data_i (wr1_data),
    .busy_o     (busy),
    .wr_drop_o  (wr_drop)
`ifdef TOAST_REGFILE_SCOREBOARD_EN
    ,
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .rs_pend_o  (rs_pend)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a count of clear cycles still to run, plus plain arrays.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  int            m_clr_left = 0;
  bit            m_drop = 1'b0;
  bit            m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid    = 1'b1;
      m_clr_left = DEPTH - 1;
      m_drop     = 1'b0;
      foreach (m_mem[i]) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else if (m_valid) begin
      m_drop = (wr0_en || wr1_en) && (m_clr_left > 0);
      if (m_clr_left > 0) begin
        m_clr_left--;
      end else begin
        if (wr0_en && wr0_addr != 0) begin m_mem[wr0_addr] = wr0_data; m_pend[wr0_addr] = 1'b0; end
        if (wr1_en && wr1_addr != 0) begin m_mem[wr1_addr] = wr1_data; m_pend[wr1_addr] = 1'b0; end
`ifdef TOAST_REGFILE_SCOREBOARD_EN
        if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
`endif
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (m_clr_left > 0 || a == 0) return '0;
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_pend(input logic [AW-1:0] a);
    if (m_clr_left > 0 || a == 0) return 1'b0;
    if ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", {63'd0, busy}, {63'd0, m_clr_left > 0});
      check("wr_drop", {63'd0, wr_drop}, {63'd0, m_drop});
      for (int k = 0; k < NP; k++) begin
        check($sformatf("rd_lane%0d_a%0d", k, rs_addr[k*AW +: AW]),
              {32'd0, rs_data[k*DW +: DW]}, {32'd0, exp_rd(rs_addr[k*AW +: AW])});
`ifdef TOAST_REGFILE_SCOREBOARD_EN
        check($sformatf("pend_lane%0d", k), {63'd0, rs_pend[k]},
              {63'd0, exp_pend(rs_addr[k*AW +: AW])});
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0;
    wr1_en = 1'b0;
`ifdef TOAST_REGFILE_SCOREBOARD_EN
    rsv_en = 1'b0;
`endif
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rs_addr = {a1, a0};
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check(nm, 64'(n), 64'd31);
    $display("[TB] %s: busy cycles %0d", nm, n);
  endtask

  initial begin
    reset = 1'b1;
    rs_addr = '0;
    wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
`ifdef TOAST_REGFILE_SCOREBOARD_EN
    rsv_addr = '0;
`endif
    idle();

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    count_busy("busy_len_init");

    // Every entry must read zero after the clear.
    for (int i = 1; i < DEPTH; i++) begin
      cyc();
      set_rd(AW'(i), AW'(DEPTH - i));
      @(negedge clk);
      check($sformatf("clr_read_x%0d", i), {32'd0, rs_data[DW-1:0]}, 64'd0);
    end
    $display("[TB] post-clear reads done");

    // Port 0 write: bypass in the write cycle, array afterwards.
    cyc();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    set_rd(5'd5, 5'd0);
    @(negedge clk);
    check("x5_bypass", {32'd0, rs_data[DW-1:0]}, 64'hDEADBEEF);
    cyc();
    idle();
    @(negedge clk);
    check("x5_array", {32'd0, rs_data[DW-1:0]}, 64'hDEADBEEF);
    $display("[TB] x5 write done");

    // Both ports to x7: port 1 wins.
    cyc();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11111111;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22222222;
    set_rd(5'd7, 5'd7);
    @(negedge clk);
    check("x7_byp_l0", {32'd0, rs_data[DW-1:0]}, 64'h22222222);
    check("x7_byp_l1", {32'd0, rs_data[2*DW-1:DW]}, 64'h22222222);
    cyc();
    idle();
    @(negedge clk);
    check("x7_arr_l0", {32'd0, rs_data[DW-1:0]}, 64'h22222222);
    check("x7_arr_l1", {32'd0, rs_data[2*DW-1:DW]}, 64'h22222222);
    $display("[TB] x7 dual write done");

    // Writes to x0 are silently ignored.
    cyc();
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
    set_rd(5'd0, 5'd0);
    @(negedge clk);
    check("x0_byp", {32'd0, rs_data[DW-1:0]}, 64'd0);
    cyc();
    idle();
    @(negedge clk);
    check("x0_arr", {32'd0, rs_data[DW-1:0]}, 64'd0);
    check("x0_nodrop", {63'd0, wr_drop}, 64'd0);
    $display("[TB] x0 write done");

    // Distinct addresses on both ports, then a short mixed sequence.
    cyc();
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h0000000A;
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h0000000B;
    set_rd(5'd4, 5'd3);
    @(negedge clk);
    check("x4_byp", {32'd0, rs_data[DW-1:0]}, 64'hB);
    check("x3_byp", {32'd0, rs_data[2*DW-1:DW]}, 64'hA);
    for (int i = 0; i < 24; i++) begin
      cyc();
      wr0_en = (i % 3) != 0; wr0_addr = AW'(i * 7 + 1); wr0_data = 32'h1000 + 32'(i);
      wr1_en = (i % 4) != 1; wr1_addr = AW'(i * 5 + 2); wr1_data = 32'h2000 + 32'(i);
      set_rd(AW'(i * 7 + 1), AW'(i * 3));
    end
    cyc();
    idle();
    $display("[TB] mixed sequence done");

    // Write dropped during clear, then reset reasserted mid-clear.
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;                       // clear cycle 1 starts here
    repeat (9) cyc();                   // clear cycle 10
    wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'h00000123;
    set_rd(5'd6, 5'd6);
    @(negedge clk);
    check("clr_rd_zero", {32'd0, rs_data[DW-1:0]}, 64'd0);
    cyc();
    idle();
    @(negedge clk);
    check("drop_pulse", {63'd0, wr_drop}, 64'd1);
    cyc();
    @(negedge clk);
    check("drop_end", {63'd0, wr_drop}, 64'd0);
    repeat (8) cyc();                   // clear cycle 20
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    count_busy("busy_len_restart");
    cyc();
    set_rd(5'd5, 5'd6);
    @(negedge clk);
    check("x5_recleared", {32'd0, rs_data[DW-1:0]}, 64'd0);
    check("x6_dropped", {32'd0, rs_data[2*DW-1:DW]}, 64'd0);

`ifdef TOAST_REGFILE_SCOREBOARD_EN
    cyc();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_rd(5'd9, 5'd0);
    @(negedge clk);
    check("pend_before", {63'd0, rs_pend[0]}, 64'd0);
    cyc();
    idle();
    @(negedge clk);
    check("pend_set", {63'd0, rs_pend[0]}, 64'd1);
    check("pend_x0", {63'd0, rs_pend[1]}, 64'd0);
    cyc();
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h5;
    @(negedge clk);
    check("pend_bypass", {63'd0, rs_pend[0]}, 64'd0);
    check("x9_byp", {32'd0, rs_data[DW-1:0]}, 64'h5);
    cyc();
    idle();
    @(negedge clk);
    check("pend_cleared", {63'd0, rs_pend[0]}, 64'd0);
    cyc();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h7;
    @(negedge clk);
    cyc();
    idle();
    @(negedge clk);
    check("pend_rsv_wins", {63'd0, rs_pend[0]}, 64'd1);
    check("x9_data", {32'd0, rs_data[DW-1:0]}, 64'h7);
    $display("[TB] scoreboard sequence done");
`endif

    cyc();
    idle();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/toast_regfile_mp.md
Name: toast_regfile_mp

Overview:
- Parametrised successor to the core's integer register file.
- N combinational read ports, two write ports (WB0 = older, WB1 = younger instruction), same-cycle write-through bypass, x0 hardwired to zero.
- Adds a sequential clear engine: after reset it zeroes every entry, one per cycle, so the array stays RAM-mappable (no per-entry reset).
- Sits between ID (reads) and WB (writes) in the dual-issue-ready pipeline.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width.
- DEPTH, 32, number of registers; must equal 2**ADDR_WIDTH.
- NUM_RD_PORTS, 2, number of read ports (1..4).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  synchronous reset, active-high.
- rs_addr_i  in  NUM_RD_PORTS*ADDR_WIDTH  packed read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- rs_data_o  out  NUM_RD_PORTS*DATA_WIDTH  packed read data, same packing.
- wr0_en_i  in  1  write enable, port 0.
- wr0_addr_i  in  ADDR_WIDTH  write address, port 0.
- wr0_data_i  in  DATA_WIDTH  write data, port 0.
- wr1_en_i  in  1  write enable, port 1 (younger).
- wr1_addr_i  in  ADDR_WIDTH  write address, port 1.
- wr1_data_i  in  DATA_WIDTH  write data, port 1.
- busy_o  out  1  clear engine active; pipeline must stall.
- wr_drop_o  out  1  one-cycle pulse: an enabled write was discarded because busy_o=1.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high, reset_i.
- FSM states:
  - CLEAR: writes 0 to entry clr_idx; clr_idx increments each cycle from 1 to DEPTH-1.
  - RUN.
- Reset behaviour:
  - While reset_i=1: state=CLEAR, clr_idx=1, busy_o=1, wr_drop_o=0.
  - After reset_i falls, CLEAR lasts exactly DEPTH-1 cycles (31 by default); entry DEPTH-1 is written on the last one.
  - busy_o falls on the edge that moves the FSM to RUN.
  - reset_i reasserted mid-clear restarts at clr_idx=1.
  - Array contents are never initialised other than by the clear engine.
- While busy_o=1:
  - every rs_data_o lane reads 0;
  - port writes are discarded;
  - wr_drop_o = registered (wr0_en_i|wr1_en_i) & busy state, i.e. it pulses the cycle after the dropped write.
- Writes in RUN:
  - A port writes its entry on the clock edge when its enable is set and its address is nonzero.
  - Writes to address 0 are ignored silently (no drop pulse).
  - Both ports enabled to the same nonzero address: port 1 data is stored.
- Reads (combinational, zero latency), per lane k:
  - addr 0 → 0.
  - Else if wr1_en_i and wr1_addr_i matches → wr1_data_i.
  - Else if wr0_en_i and wr0_addr_i matches → wr0_data_i.
  - Else → array entry.
  - Port 1 bypass has priority over port 0, which matches the store rule.
- Written data is visible from the array on the cycle after the write edge; the bypass covers the write cycle itself.
- No width arithmetic beyond index compare. clr_idx is ADDR_WIDTH bits and stops at DEPTH-1; it does not wrap into RUN.

Optional Feature:
- Macro: TOAST_REGFILE_SCOREBOARD_EN.
- When defined, the block adds a DEPTH-bit pending scoreboard and these ports:
  - rsv_en_i (1 bit) and rsv_addr_i (ADDR_WIDTH): in RUN, a nonzero rsv_addr_i sets its pending bit on the edge.
  - rs_pend_o (NUM_RD_PORTS bits): combinational per lane; 1 if the lane's entry is pending and not cleared by a same-cycle write bypass; always 0 for addr 0.
- Clearing rules:
  - A port write in RUN clears its entry's pending bit.
  - Reserve and write to the same address in the same cycle: reserve wins, so the bit stays set.
  - Reset and CLEAR zero all pending bits.
- When not defined: the ports are absent and there is no scoreboard logic.

Decomposition:
- Shared package toast_regfile_pkg holds:
  - state encoding: CLEAR=1'b0, RUN=1'b1;
  - default width constants;
  - the lane slice helper function.
- One natural sub-module, toast_regfile_rdport: one combinational read lane with bypass priority, instantiated NUM_RD_PORTS times via generate.
- FSM, array and scoreboard stay in the top module.

Test Plan:
- Reset 3 cycles then release: busy_o=1 for exactly 31 cycles, then 0. Reading addresses 1..31 then returns 0; wr_drop_o stays 0.
- In RUN, write x5=0xDEADBEEF via port 0: lane 0 with rs=5 shows 0xDEADBEEF the same cycle (bypass) and the next cycle (array).
- Same cycle, wr0 x7=0x11111111 and wr1 x7=0x22222222: both lanes reading 7 show 0x22222222 in that cycle and afterwards.
- Write x0=0xFFFFFFFF on both ports: reads of x0 return 0, wr_drop_o=0.
- Write during clear cycle 10: write discarded, wr_drop_o=1 for one cycle. Reassert reset at clear cycle 20: busy_o stays high 31 further cycles after release.
- (SCOREBOARD_EN) Reserve x9, then rs_pend_o=1 on a lane reading 9. Write x9=0x5 via port 1: rs_pend_o=0 in the write cycle and cleared after. Reserve and write x9 in the same cycle: bit remains 1.
